spi_master_sched: RTL and testbench
===================================

SPI_MASTER_SCHED -- requirements
Module: spi_master_sched

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning pclk cycles per sclk half-period (legal range 1..255).
REQ-002 SHALL have parameter NUM_REQ, default 2, meaning number of requesters (fixed at 2 in this revision).
REQ-003 SHALL have port pclk  in  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port n_p_reset  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  in  2  transfer request, one bit per requester.
REQ-006 SHALL have port req_ready  out  2  request accepted this cycle, one bit per requester.
REQ-007 SHALL have port req_ss  in  4  slave index, 2 bits per requester; requester r uses bits [2r+1:2r].
REQ-008 SHALL have port req_data  in  16  transmit byte, 8 bits per requester; requester r uses bits [8r+7:8r].
REQ-009 SHALL have port rsp_valid  out  2  one-cycle transfer-complete pulse to the owning requester.
REQ-010 SHALL have port rsp_data  out  8  byte received on mi.
REQ-011 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-012 SHALL have SPI master ports:
- n_ss_out  out  4  active-low slave selects.
- n_ss_en  out  1  active-low select drive enable.
- sclk_out  out  1  serial clock.
- n_sclk_en  out  1  active-low clock drive enable.
- mo  out  1  MOSI data.
- n_mo_en  out  1  active-low MOSI drive enable.
- mi  in  1  MISO data.

Function
REQ-013 SHALL implement states IDLE, SETUP, SHIFT, HOLD and DONE, using SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
REQ-014 In IDLE, the block SHALL assert req_ready only to the round-robin winner among requesters with req_valid high; req_ready SHALL be 0 in all other states.
REQ-015 Round-robin rule:
- A single requester with req_valid high SHALL win.
- When both are valid, the requester not granted most recently SHALL win.
- After reset, requester 0 SHALL win a tie.
REQ-016 On accept (req_valid & req_ready), the block SHALL:
- capture req_ss, req_data and the owner index;
- enter SETUP on the next cycle;
- ignore later changes on the request inputs for that transfer.
REQ-017 SETUP SHALL last CLK_DIV cycles with:
- n_ss_out[captured index]=0 and all other select bits 1;
- n_ss_en=n_sclk_en=n_mo_en=0;
- sclk_out=0;
- mo=tx bit 7.
REQ-018 SHIFT SHALL last 16*CLK_DIV cycles, with sclk_out toggling after every CLK_DIV cycles, starting high.
REQ-019 On each sclk rising edge, mi SHALL be shifted into the rx register LSB.
REQ-020 On each sclk falling edge except the last, mo SHALL advance to the next lower tx bit.
REQ-021 HOLD SHALL last CLK_DIV cycles with sclk_out=0 and the selected n_ss_out still 0.
REQ-022 DONE SHALL last 1 cycle with:
- n_ss_out=4'hF and all enables 1;
- rsp_valid[owner]=1;
- rsp_data=the received byte.
The block SHALL return to IDLE on the next cycle.
REQ-023 Latency SHALL be fixed: rsp_valid is asserted exactly 18*CLK_DIV+1 cycles after the accept edge (37 cycles for CLK_DIV=2).
REQ-024 rsp_data SHALL hold its value until the next DONE.
REQ-025 At most one bit of rsp_valid SHALL be high in any cycle.
REQ-026 Back-to-back requests:
- A request valid in IDLE SHALL be accepted in the first IDLE cycle after DONE.
- n_ss_out SHALL be high for at least 2 cycles (DONE and IDLE) between frames.
REQ-027 In IDLE, outputs SHALL be: n_ss_out=4'hF, all enables=1, sclk_out=0, mo=0.
REQ-028 A single internal counter SHALL count pclk cycles within the current half-period (0..CLK_DIV-1), and a 5-bit counter SHALL count half-periods; neither SHALL wrap during a frame.

Reset
REQ-029 When n_p_reset=0 at a rising pclk edge, the block SHALL enter IDLE with the REQ-027 output values, req_ready=0, rsp_valid=0, rsp_data=0 and busy=0, and set the round-robin pointer so requester 0 wins the next tie.
REQ-030 Reset asserted mid-transfer SHALL abort the frame: no rsp_valid is issued, and selects release on the next edge.

Structure
REQ-031 Package spi_sched_pkg SHALL hold:
- the state enum;
- DATA_W=8, NUM_SS=4, NUM_REQ=2;
- the half-period count constant (16).
REQ-032 Round-robin arbitration SHALL be implemented in sub-module spi_rr_arb (inputs req[1:0], update; output one-hot gnt[1:0]); sequencing and shifting SHALL stay in spi_master_sched.

Verification
REQ-033 With CLK_DIV=2, req_valid=2'b01, req_data[7:0]=8'hA5, req_ss[1:0]=2, and mi driven with 8'h3C on sclk rising edges, the bench SHALL check:
- mo carries 1,0,1,0,0,1,0,1;
- only n_ss_out[2] goes low;
- rsp_valid=2'b01 with rsp_data=8'h3C, 37 cycles after accept.
REQ-034 With both requesters valid continuously, the bench SHALL check that grants alternate 0,1,0,1 and that rsp_valid goes to the matching owner each time.
REQ-035 With CLK_DIV=1 and req_data=8'hFF, the bench SHALL check:
- sclk_out has 8 high pulses of 1 cycle each;
- rsp_valid arrives 19 cycles after accept.
REQ-036 With n_p_reset pulsed low during SHIFT (cycle 10 after accept), the bench SHALL check:
- n_ss_out=4'hF on the next edge;
- no rsp_valid is issued;
- the next request is accepted normally with requester 0 winning a tie.
REQ-037 With req_data and req_ss changed one cycle after accept, the bench SHALL check that the frame still transmits the captured values.
REQ-038 For a request valid during DONE, the bench SHALL check that the accept occurs in the following IDLE cycle and that n_ss_out stays high for exactly 2 cycles between frames.

Source files
------------

// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: shared state encoding and sizing constants for the SPI master scheduler
package spi_sched_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_e;
  localparam int DATA_W = 8;
  localparam int NUM_SS = 4;
  localparam int NUM_REQ = 2;
  localparam int HALF_CNT = 16;
endpackage

// File: rtl/spi_rr_arb.sv
// spi_rr_arb: two-way round-robin arbiter; on a tie the requester not granted last wins
module spi_rr_arb (
  input  logic       pclk,
  input  logic       n_p_reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);
  logic last_q;
  assign gnt = {req[1] & (~req[0] | ~last_q), req[0] & (~req[1] | last_q)};
  // last_q=1 means requester 1 was granted last, so reset makes requester 0 win ties
  always_ff @(posedge pclk)
    if (!n_p_reset) last_q <= 1'b1;
    else if (update) last_q <= gnt[1];
endmodule

// File: rtl/spi_master_sched.sv
// spi_master_sched: arbitrated mode-0 SPI master, MSB-first 8-bit frames with fixed latency
module spi_master_sched #(
  parameter int CLK_DIV = 2,
  parameter int NUM_REQ = 2
) (
  input  logic                                      pclk,
  input  logic                                      n_p_reset,
  input  logic [NUM_REQ-1:0]                        req_valid,
  output logic [NUM_REQ-1:0]                        req_ready,
  input  logic [2*NUM_REQ-1:0]                      req_ss,
  input  logic [spi_sched_pkg::DATA_W*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]                        rsp_valid,
  output logic [spi_sched_pkg::DATA_W-1:0]          rsp_data,
  output logic                                      busy,
  output logic [spi_sched_pkg::NUM_SS-1:0]          n_ss_out,
  output logic                                      n_ss_en,
  output logic                                      sclk_out,
  output logic                                      n_sclk_en,
  output logic                                      mo,
  output logic                                      n_mo_en,
  input  logic                                      mi
);
  import spi_sched_pkg::*;
  state_e state_q;
  logic [7:0] cnt_q;
  logic [4:0] half_q;
  logic [DATA_W-1:0] tx_q, rx_q, rsp_data_q, data_sel;
  logic [NUM_SS-1:0] n_ss_q;
  logic [NUM_REQ-1:0] rsp_valid_q, gnt;
  logic [1:0] ss_sel;
  logic own_q, en_n_q, sclk_q, accept, last;
  spi_rr_arb u_arb (
    .pclk(pclk),
    .n_p_reset(n_p_reset),
    .req(req_valid),
    .update(accept),
    .gnt(gnt)
  );
  assign req_ready = state_q == IDLE ? gnt : '0;
  assign accept = |(req_valid & req_ready);
  assign last = cnt_q == 8'(CLK_DIV - 1);
  assign ss_sel = gnt[1] ? req_ss[3:2] : req_ss[1:0];
  assign data_sel = gnt[1] ? req_data[15:8] : req_data[7:0];
  assign busy = state_q != IDLE;
  assign n_ss_out = n_ss_q;
  assign n_ss_en = en_n_q;
  assign n_sclk_en = en_n_q;
  assign n_mo_en = en_n_q;
  assign sclk_out = sclk_q;
  assign mo = tx_q[DATA_W-1];
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  always_ff @(posedge pclk) begin
    if (!n_p_reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      half_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      own_q <= 1'b0;
      en_n_q <= 1'b1;
      sclk_q <= 1'b0;
      n_ss_q <= '1;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      cnt_q <= (state_q == IDLE || state_q == DONE || last) ? '0 : cnt_q + 8'd1;
      case (state_q)
        IDLE: if (accept) begin
          state_q <= SETUP;
          own_q <= gnt[1];
          tx_q <= data_sel;
          n_ss_q <= ~(NUM_SS'(1) << ss_sel);
          en_n_q <= 1'b0;
        end
        SETUP: if (last) begin
          state_q <= SHIFT;
          sclk_q <= 1'b1;
          half_q <= '0;
          rx_q <= {rx_q[DATA_W-2:0], mi};
        end
        SHIFT: if (last) begin
          half_q <= half_q + 5'd1;
          if (half_q == 5'(HALF_CNT - 1)) begin
            state_q <= HOLD;
            sclk_q <= 1'b0;
          end else begin
            sclk_q <= ~sclk_q;
            // low->high samples mi; high->low advances mo, except after the final high phase
            if (!sclk_q) rx_q <= {rx_q[DATA_W-2:0], mi};
            else if (half_q != 5'(HALF_CNT - 2)) tx_q <= tx_q << 1;
          end
        end
        HOLD: if (last) begin
          state_q <= DONE;
          n_ss_q <= '1;
          en_n_q <= 1'b1;
          tx_q <= '0;
          rsp_valid_q <= NUM_REQ'(1) << own_q;
          rsp_data_q <= rx_q;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_sched.sv
// tb_spi_master_sched: two DUTs (CLK_DIV=2 and 1) checked every cycle against a
// frame-offset model, plus literal expectations for the directed scenarios.
module tb_spi_master_sched;
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;
  logic n_p_reset [2];
  logic [1:0] req_valid [2], req_ready [2], rsp_valid [2];
  logic [3:0] req_ss [2], n_ss_out [2];
  logic [15:0] req_data [2];
  logic [7:0] rsp_data [2], mi_byte [2];
  logic busy [2], n_ss_en [2], sclk_out [2], n_sclk_en [2], mo [2], n_mo_en [2], mi [2];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s dut%0d t=%0t: got %0h want %0h", name, i, $time, got, want);
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int D = g == 0 ? 2 : 1;
    spi_master_sched #(.CLK_DIV(D), .NUM_REQ(2)) dut (
      .pclk(pclk), .n_p_reset(n_p_reset[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_ss(req_ss[g]), .req_data(req_data[g]),
      .rsp_valid(rsp_valid[g]), .rsp_data(rsp_data[g]), .busy(busy[g]),
      .n_ss_out(n_ss_out[g]), .n_ss_en(n_ss_en[g]), .sclk_out(sclk_out[g]),
      .n_sclk_en(n_sclk_en[g]), .mo(mo[g]), .n_mo_en(n_mo_en[g]), .mi(mi[g])
    );
    // k counts cycles since the accept cycle (k=0); every output is a function of k
    initial begin
      int k, h, ns, r;
      bit act, last, own;
      logic sc, mb;
      logic [7:0] dat, mib, rexp;
      logic [3:0] nss;
      logic [1:0] win;
      logic [9:0] got_b, exp_b, msk;
      act = 0; last = 1; own = 0; k = 0; dat = 0; mib = 0; rexp = 0; nss = '1;
      mi[g] = 1'b0;
      forever begin
        @(negedge pclk);
        if (n_p_reset[g] !== 1'b1) begin
          act = 0; last = 1; rexp = 0; mi[g] = 1'b0;
          continue;
        end
        got_b = {n_ss_out[g], n_ss_en[g], n_sclk_en[g], n_mo_en[g], sclk_out[g], mo[g], busy[g]};
        msk = '1;
        if (act) begin
          k++;
          if (k == 18 * D + 1) begin
            rexp = mib;
            exp_b = {4'hF, 3'b111, 1'b0, 1'b0, 1'b1};
            msk[1] = 1'b0;
            chk("rsp_valid_done", g, rsp_valid[g], own ? 2'b10 : 2'b01);
            act = 0;
          end else begin
            if (k <= D) begin
              sc = 1'b0; mb = dat[7];
            end else if (k <= 17 * D) begin
              h = (k - D - 1) / D;
              sc = (h % 2) == 0;
              ns = (h + 1) / 2;
              if (ns > 7) ns = 7;
              mb = dat[7 - ns];
            end else begin
              sc = 1'b0; mb = dat[0];
            end
            exp_b = {nss, 3'b000, sc, mb, 1'b1};
            chk("rsp_valid_frame", g, rsp_valid[g], 2'b00);
          end
          chk("req_ready_frame", g, req_ready[g], 2'b00);
        end else begin
          win = (req_valid[g] == 2'b11) ? (last ? 2'b01 : 2'b10) : req_valid[g];
          exp_b = {4'hF, 3'b111, 1'b0, 1'b0, 1'b0};
          chk("req_ready_idle", g, req_ready[g], win);
          chk("rsp_valid_idle", g, rsp_valid[g], 2'b00);
          if (|(req_valid[g] & win)) begin
            act = 1; k = 0; own = win[1]; last = own;
            dat = own ? req_data[g][15:8] : req_data[g][7:0];
            nss = ~(4'b0001 << (own ? req_ss[g][3:2] : req_ss[g][1:0]));
            mib = mi_byte[g];
          end
        end
        chk("pins", g, got_b & msk, exp_b & msk);
        chk("rsp_data", g, rsp_data[g], rexp);
        // present the next miso bit before each sclk rise
        if (act) begin
          r = (k <= D) ? 0 : (k - D - 1) / (2 * D) + 1;
          if (r > 7) r = 7;
          mi[g] = mib[7 - r];
        end else mi[g] = 1'b0;
      end
    end
  end

  task automatic send(input int i, input int r, input logic [1:0] ss, input logic [7:0] d, input logic [7:0] mb);
    bit ok = 0;
    @(posedge pclk); #1;
    mi_byte[i] = mb;
    req_ss[i][2*r +: 2] = ss;
    req_data[i][8*r +: 8] = d;
    req_valid[i][r] = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge pclk);
      ok = |(req_valid[i] & req_ready[i]);
    end
    chk("accept", i, ok, 1);
    @(posedge pclk); #1;
    req_valid[i] = 2'b00;
  endtask

  task automatic watch(input int i, output int lat, output logic [7:0] mob, output logic [3:0] nsa,
                       output int rises, output int highs, output logic [1:0] rv, output logic [7:0] rd);
    logic prev = 1'b0;
    lat = -1; mob = 0; nsa = '1; rises = 0; highs = 0; rv = 0; rd = 0;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      @(negedge pclk);
      if (sclk_out[i] && !prev) begin
        rises++;
        mob = {mob[6:0], mo[i]};
      end
      if (sclk_out[i]) highs++;
      prev = sclk_out[i];
      nsa &= n_ss_out[i];
      if (rsp_valid[i] != 2'b00) begin
        lat = n; rv = rsp_valid[i]; rd = rsp_data[i];
      end
    end
  endtask

  task automatic pulse_reset(input int i);
    @(posedge pclk); #1;
    n_p_reset[i] = 1'b0;
    @(posedge pclk); #1;
    n_p_reset[i] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rises, highs, cnt, ng, no, cyc, done_cyc, run;
    int gr [8], ow [8];
    bit seen_low, acc;
    logic [7:0] mob, rd;
    logic [3:0] nsa;
    logic [1:0] rv;
    for (int i = 0; i < 2; i++) begin
      n_p_reset[i] = 1'b0; req_valid[i] = 0; req_ss[i] = 0; req_data[i] = 0; mi_byte[i] = 0;
    end
    for (int j = 0; j < 8; j++) begin gr[j] = 0; ow[j] = 0; end
    repeat (3) @(posedge pclk);
    #1;
    n_p_reset[0] = 1'b1; n_p_reset[1] = 1'b1;
    @(negedge pclk);
    chk("reset_rsp_data", 0, rsp_data[0], 8'h00);
    chk("reset_nss", 0, n_ss_out[0], 4'hF);
    chk("reset_busy", 0, busy[0], 1'b0);
    // A5 out, 3C in, slave 2
    send(0, 0, 2'd2, 8'hA5, 8'h3C);
    watch(0, lat, mob, nsa, rises, highs, rv, rd);
    chk("lat37", 0, lat, 37);
    chk("mo_bits", 0, mob, 8'hA5);
    chk("ss2_only", 0, nsa, 4'b1011);
    chk("rv_owner0", 0, rv, 2'b01);
    chk("rx_3c", 0, rd, 8'h3C);
    for (int n = 0; n < 6; n++) begin
      send(0, $urandom_range(0, 1), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      watch(0, lat, mob, nsa, rises, highs, rv, rd);
      chk("lat_rand", 0, lat, 37);
      repeat ($urandom_range(0, 3)) @(posedge pclk);
    end
    // inputs scrambled right after accept must not affect the frame
    send(0, 1, 2'd1, 8'h5A, 8'hC3);
    req_data[0] = 16'($urandom);
    req_ss[0] = 4'($urandom);
    watch(0, lat, mob, nsa, rises, highs, rv, rd);
    chk("captured_mo", 0, mob, 8'h5A);
    chk("captured_ss", 0, nsa, 4'b1101);
    chk("rv_owner1", 0, rv, 2'b10);
    chk("rx_c3", 0, rd, 8'hC3);
    // abort during SHIFT
    send(0, 0, 2'd3, 8'h96, 8'h11);
    repeat (9) @(negedge pclk);
    pulse_reset(0);
    @(negedge pclk);
    chk("abort_nss", 0, n_ss_out[0], 4'hF);
    chk("abort_busy", 0, busy[0], 1'b0);
    cnt = 0;
    repeat (60) begin
      @(negedge pclk);
      if (rsp_valid[0] != 2'b00) cnt++;
    end
    chk("abort_no_rsp", 0, cnt, 0);
    @(posedge pclk); #1;
    req_valid[0] = 2'b11;
    @(negedge pclk);
    chk("tie_after_reset", 0, req_ready[0], 2'b01);
    @(posedge pclk); #1;
    req_valid[0] = 2'b00;
    watch(0, lat, mob, nsa, rises, highs, rv, rd);
    chk("lat_after_abort", 0, lat, 37);
    chk("rv_after_abort", 0, rv, 2'b01);
    // both requesters held valid: alternating grants, back-to-back frames
    pulse_reset(0);
    ng = 0; no = 0; cyc = 0; done_cyc = -10; run = 0; seen_low = 0;
    @(posedge pclk); #1;
    req_valid[0] = 2'b11; req_data[0] = 16'($urandom); mi_byte[0] = 8'($urandom);
    while (no < 4 && cyc < 400) begin
      @(negedge pclk);
      cyc++;
      acc = |(req_valid[0] & req_ready[0]);
      if (acc) begin
        if (ng < 8) gr[ng] = int'(req_ready[0][1]);
        if (ng > 0) chk("accept_after_done", 0, cyc - done_cyc, 1);
        ng++;
      end
      if (rsp_valid[0] != 2'b00) begin
        if (no < 8) ow[no] = int'(rsp_valid[0]);
        no++;
        done_cyc = cyc;
      end
      if (n_ss_out[0] == 4'hF) run++;
      else begin
        if (seen_low && run > 0) chk("ss_gap", 0, run, 2);
        run = 0;
        seen_low = 1;
      end
      @(posedge pclk); #1;
      req_data[0] = 16'($urandom);
      req_ss[0] = 4'($urandom);
      if (acc) mi_byte[0] = 8'($urandom);
    end
    req_valid[0] = 2'b00;
    chk("rr_frames", 0, no, 4);
    for (int j = 0; j < 4; j++) begin
      chk("grant_order", 0, gr[j], j % 2);
      chk("rsp_owner", 0, ow[j], (j % 2) ? 2 : 1);
    end
    // CLK_DIV=1 instance
    send(1, 0, 2'd0, 8'hFF, 8'($urandom));
    watch(1, lat, mob, nsa, rises, highs, rv, rd);
    chk("div1_pulses", 1, rises, 8);
    chk("div1_high_cycles", 1, highs, 8);
    chk("div1_lat19", 1, lat, 19);
    chk("div1_mo", 1, mob, 8'hFF);
    for (int n = 0; n < 4; n++) begin
      send(1, $urandom_range(0, 1), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      watch(1, lat, mob, nsa, rises, highs, rv, rd);
      chk("div1_lat_rand", 1, lat, 19);
    end
    repeat (5) @(posedge pclk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
